// File: rtl/receiver_uart.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, start-glitch
// rejection and framing-error detection with a wait-for-idle-line guard.
module receiver_uart #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_END = CW'(H - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    sh, sh_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt, ferr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx_in};
  end
  assign rx_s = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      sh        <= sh_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    sh_nxt    = sh;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_nxt     = '0;
          sh_nxt[idx] = rx_s;
          idx_nxt     = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = sh;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // a held-low line (break) must not be mistaken for a new start bit
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_receiver_uart.sv
// Directed bench for receiver_uart: table of frames plus hand-written
// sequences for back-to-back, glitch, framing error and mid-frame reset.
module tb_receiver_uart;
  localparam int CPB = 16;
  localparam int LAT = 155;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  receiver_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         vcyc[$];
  logic [7:0] vdat[$];
  int         fcyc[$];
  int         both_cnt = 0, wide_cnt = 0, busy_seen = 0;
  logic       prev_v = 1'b0, prev_f = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin vcyc.push_back(cyc); vdat.push_back(rx_data); end
      if (frame_err) fcyc.push_back(cyc);
      if (rx_valid && frame_err) both_cnt++;
      if ((rx_valid && prev_v) || (frame_err && prev_f)) wide_cnt++;
      if (busy) busy_seen = 1;
    end
    prev_v = rx_valid;
    prev_f = frame_err;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    vcyc.delete(); vdat.delete(); fcyc.delete(); busy_seen = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; line is left at the stop level.
  // rst_bit >= 0 aborts mid data bit with a one-cycle reset pulse.
  task automatic send(input logic [7:0] d, input logic stop, input int rst_bit, output int fall);
    fall = cyc;
    rx_in = 1'b0;
    idle(CPB);
    for (int k = 0; k < 8; k++) begin
      rx_in = d[k];
      if (k == rst_bit) begin
        idle(CPB / 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rx_in = 1'b1;
        return;
      end
      idle(CPB);
    end
    rx_in = stop;
    idle(CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  int   f0, f1, f2;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h11, 1'b1, 1, 0, 8'h11};
    vecs[4] = '{8'h3C, 1'b0, 0, 1, 8'h11};
    vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

    // reset held with a toggling line
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 rx_in = ~rx_in;
    end
    @(negedge clk);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rx_in = 1'b1;
    idle(2);
    rst = 1'b0;
    clear_mon();
    idle(1000);
    chk("idle_valid_cnt", vcyc.size(), 0);
    chk("idle_ferr_cnt", fcyc.size(), 0);
    chk("idle_busy_seen", busy_seen, 0);

    // table of single frames with idle gaps
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send(vecs[i].data, vecs[i].stop, -1, f0);
      rx_in = 1'b1;
      idle(40);
      chk($sformatf("v%0d_valid_cnt", i), vcyc.size(), vecs[i].exp_valid);
      chk($sformatf("v%0d_ferr_cnt", i), fcyc.size(), vecs[i].exp_ferr);
      chk($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_data);
      if (vcyc.size() == 1) chk($sformatf("v%0d_valid_lat", i), vcyc[0] - f0, LAT);
      if (fcyc.size() == 1) chk($sformatf("v%0d_ferr_lat", i), fcyc[0] - f0, LAT);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
    end

    // back-to-back, no idle gap
    clear_mon();
    send(8'h00, 1'b1, -1, f0);
    send(8'hFF, 1'b1, -1, f1);
    send(8'h81, 1'b1, -1, f2);
    idle(40);
    chk("b2b_cnt", vcyc.size(), 3);
    if (vcyc.size() == 3) begin
      chk("b2b_lat0", vcyc[0] - f0, LAT);
      chk("b2b_gap1", vcyc[1] - vcyc[0], 160);
      chk("b2b_gap2", vcyc[2] - vcyc[1], 160);
      chk("b2b_d0", vdat[0], 8'h00);
      chk("b2b_d1", vdat[1], 8'hFF);
      chk("b2b_d2", vdat[2], 8'h81);
    end
    chk("b2b_ferr_cnt", fcyc.size(), 0);

    // start-bit glitch, then a good frame
    clear_mon();
    rx_in = 1'b0;
    idle(3);
    rx_in = 1'b1;
    idle(40);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_valid_cnt", vcyc.size(), 0);
    chk("glitch_ferr_cnt", fcyc.size(), 0);
    clear_mon();
    send(8'h3C, 1'b1, -1, f0);
    idle(40);
    chk("post_glitch_cnt", vcyc.size(), 1);
    chk("post_glitch_data", rx_data, 8'h3C);

    // framing error with the line held low
    send(8'h11, 1'b1, -1, f0);
    idle(40);
    clear_mon();
    send(8'h3C, 1'b0, -1, f0);
    idle(100);
    chk("brk_ferr_cnt", fcyc.size(), 1);
    chk("brk_valid_cnt", vcyc.size(), 0);
    chk("brk_rx_data", rx_data, 8'h11);
    chk("brk_busy_low_line", busy, 1);
    rx_in = 1'b1;
    idle(5);
    chk("brk_busy_released", busy, 0);
    idle(300);
    chk("brk_ferr_final", fcyc.size(), 1);
    chk("brk_valid_final", vcyc.size(), 0);

    // reset during bit 4, then a good frame
    clear_mon();
    send(8'h5A, 1'b1, 4, f0);
    idle(300);
    chk("mrst_valid_cnt", vcyc.size(), 0);
    chk("mrst_ferr_cnt", fcyc.size(), 0);
    chk("mrst_rx_data", rx_data, 0);
    chk("mrst_busy", busy, 0);
    clear_mon();
    send(8'hC3, 1'b1, -1, f0);
    idle(40);
    chk("mrst_next_cnt", vcyc.size(), 1);
    chk("mrst_next_data", rx_data, 8'hC3);
    if (vcyc.size() == 1) chk("mrst_next_lat", vcyc[0] - f0, LAT);

    chk("never_both", both_cnt, 0);
    chk("strobe_width", wide_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
